hazard_scoreboard: RTL and testbench

Parametrised successor to the ID-stage hazard unit of the 5-stage RISC-V pipeline. It keeps a per-register countdown scoreboard of in-flight producers and resolves hazards from it:
- RAW stalls, including load-use.
- Extra stall cycles for branches whose compare is done in ID.
- IF flush on a taken branch.

It sits in the decode stage between the control unit and the ID/EX register. It drives PC enable, IF/ID enable and the ID/EX bubble.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hz_sb_entry.sv | 22 ++
 rtl/hazard_scoreboard.sv | 93 +++++++++
 tb/tb_hazard_scoreboard.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared opcodes, default hazard latencies and scoreboard sizing helper
package pipeline_pkg;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] SBTYPE = 7'b1100011;
  localparam logic [6:0] ITYPE  = 7'b0000011;

  localparam int DEF_ALU_LAT      = 0;
  localparam int DEF_LOAD_LAT     = 1;
  localparam int DEF_BRANCH_EXTRA = 1;

  // Wide enough for the largest preset value; never narrower than one bit.
  function automatic int cnt_width(input int alu_lat, input int load_lat, input int branch_extra);
    int m;
    int w;
    m = (alu_lat > load_lat) ? alu_lat : load_lat;
    w = $clog2(m + branch_extra + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hz_sb_entry.sv
// rtl/hz_sb_entry.sv - one scoreboard entry: saturating down-counter with parallel load
module hz_sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - ID-stage countdown scoreboard driving stalls and branch flush
// Optional HAZARD_PERF_EN adds stall_cycles / flush_count performance counters.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter  int NUM_REGS     = 32,
  parameter  int ALU_LAT      = DEF_ALU_LAT,
  parameter  int LOAD_LAT     = DEF_LOAD_LAT,
  parameter  int BRANCH_EXTRA = DEF_BRANCH_EXTRA,
  localparam int REG_AW       = $clog2(NUM_REGS),
  localparam int CNT_W        = cnt_width(ALU_LAT, LOAD_LAT, BRANCH_EXTRA)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic                id_reg_write,
  input  logic                id_is_load,
  input  logic                id_is_branch,
  input  logic                id_branch_taken,
  output logic                pc_enable,
  output logic                if_id_enable,
  output logic                id_ex_bubble,
  output logic                if_flush,
  output logic                stall_pipeline_debug,
  output logic [NUM_REGS-1:0] busy_mask
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         flush_count
`endif
);

  localparam logic [CNT_W-1:0] BR_EXTRA = CNT_W'(BRANCH_EXTRA);
  localparam logic [CNT_W-1:0] ALU_VAL  = CNT_W'(ALU_LAT + BRANCH_EXTRA);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT + BRANCH_EXTRA);

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic             hazard_rs1;
  logic             hazard_rs2;
  logic             stall;
  logic             issue;
  logic [CNT_W-1:0] new_val;

  // Branches compare in ID, so they wait out the BRANCH_EXTRA slack that forwarding covers for others.
  assign hazard_rs1 = id_use_rs1 && (id_rs1 != '0) &&
                      (id_is_branch ? (cnt[id_rs1] != '0) : (cnt[id_rs1] > BR_EXTRA));
  assign hazard_rs2 = id_use_rs2 && (id_rs2 != '0) &&
                      (id_is_branch ? (cnt[id_rs2] != '0) : (cnt[id_rs2] > BR_EXTRA));

  assign stall   = id_valid && (hazard_rs1 || hazard_rs2);
  assign issue   = id_valid && !stall;
  assign new_val = id_is_load ? LOAD_VAL : ALU_VAL;

  assign pc_enable            = !stall;
  assign if_id_enable         = !stall;
  assign id_ex_bubble         = stall || !id_valid;
  assign if_flush             = issue && id_is_branch && id_branch_taken;
  assign stall_pipeline_debug = stall;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    logic wr;
    assign wr = issue && id_reg_write && (id_rd == REG_AW'(r));
    hz_sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clock    (clock),
      .reset    (reset),
      .load     (wr),
      .load_val (new_val),
      .cnt      (cnt[r])
    );
    assign busy_mask[r] = (cnt[r] != '0);
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall)    stall_cycles <= stall_cycles + 32'd1;
      if (if_flush) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

  logic        clock;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  id_rd;
  logic        id_reg_write;
  logic        id_is_load;
  logic        id_is_branch;
  logic        id_branch_taken;
  logic        pc_enable;
  logic        if_id_enable;
  logic        id_ex_bubble;
  logic        if_flush;
  logic        stall_pipeline_debug;
  logic [31:0] busy_mask;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int errors = 0;
  int checks = 0;

  hazard_scoreboard dut (
    .clock                (clock),
    .reset                (reset),
    .id_valid             (id_valid),
    .id_rs1               (id_rs1),
    .id_rs2               (id_rs2),
    .id_use_rs1           (id_use_rs1),
    .id_use_rs2           (id_use_rs2),
    .id_rd                (id_rd),
    .id_reg_write         (id_reg_write),
    .id_is_load           (id_is_load),
    .id_is_branch         (id_is_branch),
    .id_branch_taken      (id_branch_taken),
    .pc_enable            (pc_enable),
    .if_id_enable         (if_id_enable),
    .id_ex_bubble         (id_ex_bubble),
    .if_flush             (if_flush),
    .stall_pipeline_debug (stall_pipeline_debug),
    .busy_mask            (busy_mask)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles         (stall_cycles),
    .flush_count          (flush_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        val;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        rw;
    logic        ld;
    logic        br;
    logic        tk;
    logic        e_pc;
    logic        e_bub;
    logic        e_fl;
    logic [31:0] e_busy;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic val, input int rs1, input logic u1, input int rs2,
                              input logic u2, input int rd, input logic rw, input logic ld,
                              input logic br, input logic tk, input logic e_pc,
                              input logic e_bub, input logic e_fl, input logic [31:0] e_busy);
    vec_t v;
    v.val = val; v.rs1 = 5'(rs1); v.u1 = u1; v.rs2 = 5'(rs2); v.u2 = u2;
    v.rd = 5'(rd); v.rw = rw; v.ld = ld; v.br = br; v.tk = tk;
    v.e_pc = e_pc; v.e_bub = e_bub; v.e_fl = e_fl; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.val; id_rs1 = v.rs1; id_use_rs1 = v.u1; id_rs2 = v.rs2; id_use_rs2 = v.u2;
    id_rd = v.rd; id_reg_write = v.rw; id_is_load = v.ld;
    id_is_branch = v.br; id_branch_taken = v.tk;
  endtask

  task automatic check_outs(input string tag, input logic e_pc, input logic e_bub,
                            input logic e_fl, input logic [31:0] e_busy);
    check({tag, " pc_enable"},    32'(pc_enable),            32'(e_pc));
    check({tag, " if_id_enable"}, 32'(if_id_enable),         32'(e_pc));
    check({tag, " stall_debug"},  32'(stall_pipeline_debug), 32'(!e_pc));
    check({tag, " id_ex_bubble"}, 32'(id_ex_bubble),         32'(e_bub));
    check({tag, " if_flush"},     32'(if_flush),             32'(e_fl));
    check({tag, " busy_mask"},    busy_mask,                 e_busy);
  endtask

  initial begin
    //           val rs1 u1 rs2 u2 rd rw ld br tk  pc bub fl busy
    vecs[0]  = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 32'h0);   // idle
    vecs[1]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 0, 0,  1, 0, 0, 32'h0);   // add x5
    vecs[2]  = mk(1,  5, 1,  0, 0,  6, 1, 0, 0, 0,  1, 0, 0, 32'h20);  // add x6,x5: forwarded
    vecs[3]  = mk(1,  1, 1,  0, 0,  5, 1, 1, 0, 0,  1, 0, 0, 32'h40);  // lw x5
    vecs[4]  = mk(1,  5, 1,  0, 0,  7, 1, 0, 0, 0,  0, 1, 0, 32'h20);  // load-use stall
    vecs[5]  = mk(1,  5, 1,  0, 0,  7, 1, 0, 0, 0,  1, 0, 0, 32'h20);  // issues
    vecs[6]  = mk(1,  0, 1,  0, 0,  5, 1, 1, 0, 0,  1, 0, 0, 32'h80);  // lw x5
    vecs[7]  = mk(1,  5, 1,  0, 1,  0, 0, 0, 1, 1,  0, 1, 0, 32'h20);  // beq stall 1, no flush
    vecs[8]  = mk(1,  5, 1,  0, 1,  0, 0, 0, 1, 1,  0, 1, 0, 32'h20);  // beq stall 2
    vecs[9]  = mk(1,  5, 1,  0, 1,  0, 0, 0, 1, 1,  1, 0, 1, 32'h0);   // beq issues, flush
    vecs[10] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0, 0,  1, 1, 0, 32'h0);   // squashed slot
    vecs[11] = mk(1,  1, 1,  2, 1,  0, 0, 0, 1, 1,  1, 0, 1, 32'h0);   // ready beq flushes
    vecs[12] = mk(1,  3, 1,  0, 0,  3, 1, 0, 0, 0,  1, 0, 0, 32'h0);   // add x3,x3: no self hazard
    vecs[13] = mk(1,  0, 0,  0, 0,  8, 1, 1, 0, 0,  1, 0, 0, 32'h8);   // lw x8
    vecs[14] = mk(1,  0, 0,  0, 0,  8, 1, 1, 0, 0,  1, 0, 0, 32'h100); // lw x8 reloads counter
    vecs[15] = mk(1,  8, 1,  0, 0, 10, 1, 0, 0, 0,  0, 1, 0, 32'h100); // stalls on reloaded x8
    vecs[16] = mk(1,  8, 1,  0, 0, 10, 1, 0, 0, 0,  1, 0, 0, 32'h100);
    vecs[17] = mk(0, 10, 1,  0, 0,  0, 0, 0, 1, 1,  1, 1, 0, 32'h400); // invalid never stalls/flushes

    reset = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_outs("reset", 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef HAZARD_PERF_EN
    check("reset stall_cycles", stall_cycles, 32'd0);
    check("reset flush_count",  flush_count,  32'd0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(posedge clock);
      #1;
      drive(vecs[i]);
      @(negedge clock);
      check_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_bub, vecs[i].e_fl, vecs[i].e_busy);
    end
`ifdef HAZARD_PERF_EN
    check("perf stall_cycles", stall_cycles, 32'd4);
    check("perf flush_count",  flush_count,  32'd2);
`endif

    // lw x7, consumer stalls, reset asserted mid-stall clears everything at once.
    @(posedge clock);
    #1;
    drive(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 1, 0, 0, 32'h0));
    @(negedge clock);
    check_outs("rst lw", 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    drive(mk(1, 7, 1, 0, 0, 9, 1, 0, 0, 0, 0, 1, 0, 32'h80));
    @(negedge clock);
    check_outs("rst pre", 1'b0, 1'b1, 1'b0, 32'h80);
    #1;
    reset = 1'b0;
    #1;
    check_outs("rst async", 1'b1, 1'b0, 1'b0, 32'h0);
`ifdef HAZARD_PERF_EN
    check("rst stall_cycles", stall_cycles, 32'd0);
    check("rst flush_count",  flush_count,  32'd0);
`endif
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check_outs("rst post", 1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #1;
    drive(vecs[0]);
    @(negedge clock);
    check_outs("rst after", 1'b1, 1'b1, 1'b0, 32'h200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
